tl_ctrl_multi: RTL and testbench

TL_CTRL_MULTI -- requirements
Module: tl_ctrl_multi

---
 rtl/tl_pkg.sv | 24 ++
 rtl/tl_next_sel.sv | 44 ++++
 rtl/tl_ctrl_multi.sv | 165 ++++++++++++++++
 tb/tb_tl_ctrl_multi.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared types for the multi-approach traffic-light controller: FSM states and lamp encodings.
// Lamp bits are ordered {R,Y,G}.
package tl_pkg;

    typedef enum logic [2:0] {
        DARK,
        GREEN,
        YELLOW,
        ALLRED,
        FLASH
    } tl_state_e;

    typedef struct packed {
        logic r;
        logic y;
        logic g;
    } lamp_t;

    localparam lamp_t RED = 3'b100;
    localparam lamp_t YEL = 3'b010;
    localparam lamp_t GRN = 3'b001;
    localparam lamp_t OFF = 3'b000;

endpackage

// File: rtl/tl_next_sel.sv
// Picks the next phase owner: first demanding approach after cur_idx (wrapping), emergency overrides.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module tl_next_sel
    import tl_pkg::*;
#(
    parameter int N_APPR = 4,
    parameter int IW     = $clog2(N_APPR)
) (
    input  logic [N_APPR-1:0] sensor,
    input  logic [IW-1:0]     cur_idx,
    input  logic              emg_req,
    input  logic [IW-1:0]     emg_idx,
    output logic [IW-1:0]     next_idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic [IW-1:0] wrap_idx;
    logic [IW-1:0] sel;
    logic          found;

    always_comb begin
        sum      = '0;
        cand     = '0;
        found    = 1'b0;
        wrap_idx = (cur_idx == IW'(N_APPR - 1)) ? '0 : cur_idx + 1'b1;
        sel      = wrap_idx;
        // k == N_APPR lands back on cur_idx, so a lone demanding owner is re-served.
        for (int k = 1; k <= N_APPR; k++) begin
            sum = {1'b0, cur_idx} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_APPR)) begin
                sum = sum - (IW+1)'(N_APPR);
            end
            cand = sum[IW-1:0];
            if (!found && sensor[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        next_idx = emg_req ? emg_idx : sel;
    end

endmodule

// File: rtl/tl_ctrl_multi.sv
// Multi-approach traffic-light controller with sensor demand, emergency preemption and flash mode.
// Latency: lamps and active_idx are registered and change on the same edge as the state.
// Backpressure: none; free-running timer FSM with no flow control.
module tl_ctrl_multi
    import tl_pkg::*;
#(
    parameter int N_APPR      = 4,
    parameter int TW          = 16,
    parameter int G_LONG      = 299,
    parameter int G_SHORT     = 49,
    parameter int Y_TICKS     = 29,
    parameter int R_TICKS     = 29,
    parameter int FLASH_TICKS = 4
) (
    input  logic                      clk,
    input  logic                      arstN,
    input  logic [N_APPR-1:0]         sensor,
    input  logic                      emg_req,
    input  logic [$clog2(N_APPR)-1:0] emg_idx,
    input  logic                      flash_en,
    output logic [3*N_APPR-1:0]       tl_sig_arr,
    output logic [$clog2(N_APPR)-1:0] active_idx
);

    localparam int IW = $clog2(N_APPR);

    if ((G_LONG >> TW) != 0 || (G_SHORT >> TW) != 0 || (Y_TICKS >> TW) != 0 ||
        (R_TICKS >> TW) != 0 || (FLASH_TICKS >> TW) != 0) begin : g_bad_reload
        $error("tl_ctrl_multi: a reload value does not fit in TW bits");
    end
    if (N_APPR < 2 || N_APPR > 8) begin : g_bad_n_appr
        $error("tl_ctrl_multi: N_APPR must be within 2..8");
    end

    localparam logic [TW-1:0] LD_GL = TW'(G_LONG);
    localparam logic [TW-1:0] LD_GS = TW'(G_SHORT);
    localparam logic [TW-1:0] LD_Y  = TW'(Y_TICKS);
    localparam logic [TW-1:0] LD_R  = TW'(R_TICKS);
    localparam logic [TW-1:0] LD_F  = TW'(FLASH_TICKS);

    tl_state_e            state_q, state_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        g_load_q, g_load_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 flash_on_q, flash_on_d;
    logic [3*N_APPR-1:0]  sig_q, sig_d;
    logic [IW-1:0]        next_idx;
    lamp_t                lamp_v;

    tl_next_sel #(
        .N_APPR (N_APPR),
        .IW     (IW)
    ) u_next_sel (
        .sensor   (sensor),
        .cur_idx  (idx_q),
        .emg_req  (emg_req),
        .emg_idx  (emg_idx),
        .next_idx (next_idx)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        g_load_d   = g_load_q;
        idx_d      = idx_q;
        flash_on_d = flash_on_q;

        case (state_q)
            DARK: begin
                state_d = ALLRED;
                cnt_d   = LD_R;
                idx_d   = IW'(N_APPR - 1);
            end
            GREEN: begin
                if (emg_req && emg_idx != idx_q) begin
                    state_d = YELLOW;
                    cnt_d   = LD_Y;
                end else if (emg_req) begin
                    // Owner is the preempting approach: freeze at full green until release.
                    cnt_d = g_load_q;
                end else if (cnt_q == '0) begin
                    state_d = YELLOW;
                    cnt_d   = LD_Y;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            YELLOW: begin
                if (cnt_q == '0) begin
                    state_d = ALLRED;
                    cnt_d   = LD_R;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ALLRED: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (flash_en) begin
                    state_d    = FLASH;
                    cnt_d      = LD_F;
                    flash_on_d = 1'b1;
                end else begin
                    state_d  = GREEN;
                    idx_d    = next_idx;
                    g_load_d = sensor[next_idx] ? LD_GL : LD_GS;
                    cnt_d    = sensor[next_idx] ? LD_GL : LD_GS;
                end
            end
            FLASH: begin
                if (!flash_en) begin
                    state_d    = ALLRED;
                    cnt_d      = LD_R;
                    idx_d      = IW'(N_APPR - 1);
                    flash_on_d = 1'b0;
                end else if (cnt_q == '0) begin
                    flash_on_d = ~flash_on_q;
                    cnt_d      = LD_F;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = DARK;
                cnt_d   = '0;
            end
        endcase

        // Lamps derive from next-state values so they update on the same edge as the FSM.
        sig_d  = '0;
        lamp_v = OFF;
        for (int i = 0; i < N_APPR; i++) begin
            case (state_d)
                GREEN:   lamp_v = (IW'(i) == idx_d) ? GRN : RED;
                YELLOW:  lamp_v = (IW'(i) == idx_d) ? YEL : RED;
                ALLRED:  lamp_v = RED;
                FLASH:   lamp_v = flash_on_d ? YEL : OFF;
                default: lamp_v = OFF;
            endcase
            sig_d[3*i +: 3] = lamp_v;
        end
    end

    always_ff @(posedge clk or negedge arstN) begin
        if (!arstN) begin
            state_q    <= DARK;
            cnt_q      <= '0;
            g_load_q   <= '0;
            idx_q      <= '0;
            flash_on_q <= 1'b0;
            sig_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            g_load_q   <= g_load_d;
            idx_q      <= idx_d;
            flash_on_q <= flash_on_d;
            sig_q      <= sig_d;
        end
    end

    assign tl_sig_arr = sig_q;
    assign active_idx = idx_q;

endmodule

// File: tb/tb_tl_ctrl_multi.sv
// Scoreboard bench for tl_ctrl_multi: driver steps a phase-level reference model and queues
// the expected lamps per clock; an independent monitor pops and compares after each edge.
module tb_tl_ctrl_multi;

    localparam int N  = 4;
    localparam int GL = 9;
    localparam int GS = 4;
    localparam int YT = 2;
    localparam int RT = 1;
    localparam int FT = 3;

    logic        clk = 1'b0;
    logic        arstN = 1'b0;
    logic [3:0]  sensor = '0;
    logic        emg_req = 1'b0;
    logic [1:0]  emg_idx = '0;
    logic        flash_en = 1'b0;
    logic [11:0] tl_sig_arr;
    logic [1:0]  active_idx;

    int checks = 0;
    int errors = 0;

    tl_ctrl_multi #(
        .N_APPR(N), .TW(16), .G_LONG(GL), .G_SHORT(GS),
        .Y_TICKS(YT), .R_TICKS(RT), .FLASH_TICKS(FT)
    ) dut (
        .clk        (clk),
        .arstN      (arstN),
        .sensor     (sensor),
        .emg_req    (emg_req),
        .emg_idx    (emg_idx),
        .flash_en   (flash_en),
        .tl_sig_arr (tl_sig_arr),
        .active_idx (active_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] sig;
        logic [1:0]  idx;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: a phase with an owner and a number of cycles still to be shown.
    typedef enum {M_OFF, M_GO, M_CAUTION, M_STOP, M_BLINK} mphase_t;
    mphase_t m_ph = M_OFF;
    int      m_idx = 0;
    int      m_left = 1;
    int      m_gload = 0;
    bit      m_blink_on = 0;

    function automatic int pick_next(input logic [3:0] s, input int cur);
        for (int k = 1; k <= N; k++) begin
            if (s[(cur + k) % N]) return (cur + k) % N;
        end
        return (cur + 1) % N;
    endfunction

    function automatic void model_edge(input logic [3:0] s, input logic e, input int ei,
                                       input logic f, input logic rst_n);
        int nxt;
        if (!rst_n) begin
            m_ph = M_OFF; m_idx = 0; m_left = 1; m_blink_on = 0;
            return;
        end
        case (m_ph)
            M_OFF: begin m_ph = M_STOP; m_idx = N - 1; m_left = RT + 1; end
            M_GO: begin
                if (e && ei != m_idx) begin m_ph = M_CAUTION; m_left = YT + 1; end
                else if (e) m_left = m_gload + 1;
                else if (m_left == 1) begin m_ph = M_CAUTION; m_left = YT + 1; end
                else m_left--;
            end
            M_CAUTION: begin
                if (m_left == 1) begin m_ph = M_STOP; m_left = RT + 1; end
                else m_left--;
            end
            M_STOP: begin
                if (m_left > 1) m_left--;
                else if (f) begin m_ph = M_BLINK; m_left = FT + 1; m_blink_on = 1; end
                else begin
                    nxt = e ? ei : pick_next(s, m_idx);
                    m_ph = M_GO; m_idx = nxt;
                    m_gload = s[nxt] ? GL : GS;
                    m_left = m_gload + 1;
                end
            end
            M_BLINK: begin
                if (!f) begin m_ph = M_STOP; m_left = RT + 1; m_idx = N - 1; m_blink_on = 0; end
                else if (m_left == 1) begin m_blink_on = !m_blink_on; m_left = FT + 1; end
                else m_left--;
            end
            default: m_ph = M_OFF;
        endcase
    endfunction

    function automatic exp_t model_exp();
        exp_t r;
        r.idx = 2'(m_idx);
        r.sig = '0;
        for (int a = 0; a < N; a++) begin
            case (m_ph)
                M_GO:      r.sig[3*a +: 3] = (a == m_idx) ? 3'b001 : 3'b100;
                M_CAUTION: r.sig[3*a +: 3] = (a == m_idx) ? 3'b010 : 3'b100;
                M_STOP:    r.sig[3*a +: 3] = 3'b100;
                M_BLINK:   r.sig[3*a +: 3] = m_blink_on ? 3'b010 : 3'b000;
                default:   r.sig[3*a +: 3] = 3'b000;
            endcase
        end
        return r;
    endfunction

    // Apply inputs for the coming edge, queue what that edge must produce, then wait it out.
    task automatic step(input logic [3:0] s, input logic e, input logic [1:0] ei, input logic f,
                        input logic r, input logic use_ovr, input exp_t ovr);
        sensor = s; emg_req = e; emg_idx = ei; flash_en = f; arstN = r;
        model_edge(s, e, int'(ei), f, r);
        if (use_ovr) exp_q.push_back(ovr);
        else exp_q.push_back(model_exp());
        @(negedge clk);
    endtask

    task automatic run(input logic [3:0] s, input logic e, input logic [1:0] ei, input logic f,
                       input logic r, input int n);
        for (int i = 0; i < n; i++) step(s, e, ei, f, r, 1'b0, '0);
    endtask

    // Hand-written reset-release sequence with no demand.
    task automatic run_reset_seq();
        exp_t seq[14];
        seq[0] = {12'h000, 2'd0};
        for (int i = 1; i <= 2; i++)   seq[i] = {12'h924, 2'd3};
        for (int i = 3; i <= 7; i++)   seq[i] = {12'h921, 2'd0};
        for (int i = 8; i <= 10; i++)  seq[i] = {12'h922, 2'd0};
        for (int i = 11; i <= 12; i++) seq[i] = {12'h924, 2'd0};
        seq[13] = {12'h90C, 2'd1};
        for (int i = 0; i < 14; i++) step(4'b0000, 1'b0, 2'd0, 1'b0, (i != 0), 1'b1, seq[i]);
    endtask

    int cyc = 0;
    always @(posedge clk) begin
        exp_t e;
        int   busy;
        bit   bad;
        bit   same;
        logic [2:0] l;
        #1;
        cyc++;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow: cycle %0d has no expectation", cyc);
        end else begin
            e = exp_q.pop_front();
            if (tl_sig_arr !== e.sig || active_idx !== e.idx) begin
                errors++;
                $display("FAIL lamps cycle %0d: got sig=%03h idx=%0d, want sig=%03h idx=%0d",
                         cyc, tl_sig_arr, active_idx, e.sig, e.idx);
            end
        end
        busy = 0; bad = 0; same = 1;
        for (int a = 0; a < N; a++) begin
            l = tl_sig_arr[3*a +: 3];
            if (!(l == 3'b100 || l == 3'b010 || l == 3'b001 || l == 3'b000)) bad = 1;
            if (l == 3'b010 || l == 3'b001) busy++;
            if (l != tl_sig_arr[2:0]) same = 0;
        end
        checks++;
        if (bad || (busy > 1 && !same)) begin
            errors++;
            $display("FAIL lamp_exclusive cycle %0d: got sig=%03h, want one lamp each and at most one non-red owner",
                     cyc, tl_sig_arr);
        end
    end

    int         hold;
    logic [1:0] hidx;
    logic [3:0] rs;
    logic       rf;

    initial begin
        // Power-on reset and first rotation.
        run_reset_seq();

        // Reach YELLOW, then pulse reset mid-phase and expect an immediate dark board.
        begin
            int n = 0;
            while (m_ph != M_CAUTION && n < 50) begin
                step(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, '0);
                n++;
            end
            checks++;
            if (m_ph != M_CAUTION || tl_sig_arr[5:3] !== 3'b010) begin
                errors++;
                $display("FAIL reach_yellow: got sig=%03h after %0d cycles, want idx1 yellow", tl_sig_arr, n);
            end
        end
        #3 arstN = 1'b0;
        #1;
        checks++;
        if (tl_sig_arr !== 12'h000 || active_idx !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got sig=%03h idx=%0d, want sig=000 idx=0", tl_sig_arr, active_idx);
        end
        model_edge(4'b0000, 1'b0, 0, 1'b0, 1'b0);
        run_reset_seq();

        // Constant demand on approach 2 only.
        run(4'b0100, 1'b0, 2'd0, 1'b0, 1'b0, 1);
        run(4'b0100, 1'b0, 2'd0, 1'b0, 1'b1, 60);

        // Emergency to approach 3 during idx0 green cycle 2, held, then released.
        run(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1);
        run(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 4);
        run(4'b0000, 1'b1, 2'd3, 1'b0, 1'b1, 20);
        run(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 15);

        // Flash requested during green, later withdrawn.
        run(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1);
        run(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 5);
        run(4'b0000, 1'b0, 2'd0, 1'b1, 1'b1, 45);
        run(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1, 15);

        // Randomized traffic with emergency bursts and occasional flash mode.
        hold = 0; hidx = '0; rs = '0; rf = 1'b0;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 4) == 0) rs = 4'($urandom);
            if ($urandom_range(0, 99) == 0) rf = !rf;
            if (hold > 0) hold--;
            else if ($urandom_range(0, 29) == 0) begin
                hold = $urandom_range(1, 20);
                hidx = 2'($urandom);
            end
            step(rs, (hold > 0), hidx, rf, 1'b1, 1'b0, '0);
        end

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
